// File: rtl/mux_sel_sequencer_if.sv
// Channel-write port of mux_sel_sequencer: a valid/ready handshake carrying
// the channel index and the value to store in that channel.
interface mux_sel_sequencer_if #(
    parameter int DATA_W = 2
);
    logic              wr_en;
    logic [1:0]        wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    modport master (
        output wr_en,
        output wr_idx,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_en,
        input  wr_idx,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/mux_sel_sequencer.sv
// Channel register file and select generator feeding a 4:1 mux (manual or auto-scan select).
// Optional pause input is enabled by defining MUX_SEL_SEQ_PAUSE_EN.
module mux_sel_sequencer #(
    parameter int DWELL_W = 8,
    parameter int DATA_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    mux_sel_sequencer_if.slave wr,
    input  logic               mode,
    input  logic [1:0]         man_sel,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               start,
    input  logic               stop,
`ifdef MUX_SEL_SEQ_PAUSE_EN
    input  logic               pause,
`endif
    output logic [DATA_W-1:0]  X0,
    output logic [DATA_W-1:0]  X1,
    output logic [DATA_W-1:0]  X2,
    output logic [DATA_W-1:0]  X3,
    output logic [1:0]         Y,
    output logic               busy,
    output logic               step
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         y_q, y_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               step_q, step_d;
    logic               busy_q, busy_d;
    logic [DATA_W-1:0]  x_q [4];
    logic [DATA_W-1:0]  x_d [4];

    logic               pause_s;
    logic               wr_ready_s;
    logic               wr_accept_s;

`ifdef MUX_SEL_SEQ_PAUSE_EN
    assign pause_s = pause;
`else
    assign pause_s = 1'b0;
`endif

    // The channel on display is frozen for its whole dwell; everything else is writable.
    assign wr_ready_s  = !((state_q == ST_SCAN) && (wr.wr_idx == y_q));
    assign wr_accept_s = wr.wr_en && wr_ready_s;
    assign wr.wr_ready = wr_ready_s;

    // Next-state logic for the select FSM, dwell counter and step pulse.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        step_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && mode && !stop) begin
                    state_d = ST_SCAN;
                    y_d     = 2'd0;
                    cnt_d   = {DWELL_W{1'b0}};
                    dwell_d = dwell;
                end else if (!mode) begin
                    y_d = man_sel;
                end else begin
                    y_d = y_q;
                end
            end
            ST_SCAN: begin
                if (stop || !mode) begin
                    state_d = ST_IDLE;
                    cnt_d   = {DWELL_W{1'b0}};
                end else if (pause_s) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == dwell_q) begin
                    // dwell is re-sampled at each advance so a new value takes effect per channel
                    y_d     = y_q + 2'd1;
                    cnt_d   = {DWELL_W{1'b0}};
                    step_d  = 1'b1;
                    dwell_d = dwell;
                end else begin
                    cnt_d = cnt_q + {{(DWELL_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {DWELL_W{1'b0}};
            end
        endcase
        busy_d = (state_d == ST_SCAN);
    end

    // Next-state logic for the channel registers.
    always_comb begin
        x_d = x_q;
        if (wr_accept_s) begin
            x_d[wr.wr_idx] = wr.wr_data;
        end else begin
            x_d = x_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            y_q     <= 2'd0;
            cnt_q   <= {DWELL_W{1'b0}};
            dwell_q <= {DWELL_W{1'b0}};
            step_q  <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                x_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            for (int i = 0; i < 4; i++) begin
                x_q[i] <= x_d[i];
            end
        end
    end

    assign X0   = x_q[0];
    assign X1   = x_q[1];
    assign X2   = x_q[2];
    assign X3   = x_q[3];
    assign Y    = y_q;
    assign busy = busy_q;
    assign step = step_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Self-checking bench for mux_sel_sequencer: cycle model plus directed literal checks.
// The pause scenario runs only when MUX_SEL_SEQ_PAUSE_EN is defined.
module tb_mux_sel_sequencer;
    localparam int DWELL_W = 8;
    localparam int DATA_W  = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               mode = 1'b0;
    logic [1:0]         man_sel = 2'd0;
    logic [DWELL_W-1:0] dwell = 8'd0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               pause = 1'b0;
    logic [DATA_W-1:0]  X0, X1, X2, X3;
    logic [1:0]         Y;
    logic               busy, step;

    int errors = 0;
    int checks = 0;

    int scan_y [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    int scan_s [13] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    int fast_y [6]  = '{0, 1, 2, 3, 0, 1};
    int fast_s [6]  = '{0, 1, 1, 1, 1, 1};
    int wdat   [4]  = '{1, 2, 3, 0};

    mux_sel_sequencer_if #(.DATA_W(DATA_W)) wr_if ();

    mux_sel_sequencer #(.DWELL_W(DWELL_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr      (wr_if),
        .mode    (mode),
        .man_sel (man_sel),
        .dwell   (dwell),
        .start   (start),
        .stop    (stop),
`ifdef MUX_SEL_SEQ_PAUSE_EN
        .pause   (pause),
`endif
        .X0      (X0),
        .X1      (X1),
        .X2      (X2),
        .X3      (X3),
        .Y       (Y),
        .busy    (busy),
        .step    (step)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: channel store, select value, and remaining-cycles countdown per channel.
    logic [DATA_W-1:0] m_x [4] = '{default: 2'd0};
    logic [1:0]        m_y = 2'd0;
    logic              m_scan = 1'b0;
    logic              m_step = 1'b0;
    int                m_left = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) m_x[i] <= 2'd0;
            m_y    <= 2'd0;
            m_scan <= 1'b0;
            m_step <= 1'b0;
            m_left <= 0;
        end else begin
            if (wr_if.wr_en && !(m_scan && wr_if.wr_idx == m_y))
                m_x[wr_if.wr_idx] <= wr_if.wr_data;
            m_step <= 1'b0;
            if (!m_scan) begin
                if (start && mode && !stop) begin
                    m_scan <= 1'b1;
                    m_y    <= 2'd0;
                    m_left <= int'(dwell);
                end else if (!mode) begin
                    m_y <= man_sel;
                end
            end else if (stop || !mode) begin
                m_scan <= 1'b0;
            end else if (!pause) begin
                if (m_left == 0) begin
                    m_y    <= m_y + 2'd1;
                    m_left <= int'(dwell);
                    m_step <= 1'b1;
                end else begin
                    m_left <= m_left - 1;
                end
            end
        end
    end

    // Every cycle compare DUT outputs against the model.
    always @(posedge clk) begin
        #1;
        chk("cmp_X0", {30'd0, X0}, {30'd0, m_x[0]});
        chk("cmp_X1", {30'd0, X1}, {30'd0, m_x[1]});
        chk("cmp_X2", {30'd0, X2}, {30'd0, m_x[2]});
        chk("cmp_X3", {30'd0, X3}, {30'd0, m_x[3]});
        chk("cmp_Y", {30'd0, Y}, {30'd0, m_y});
        chk("cmp_busy", {31'd0, busy}, {31'd0, m_scan});
        chk("cmp_step", {31'd0, step}, {31'd0, m_step});
        chk("cmp_wr_ready", {31'd0, wr_if.wr_ready},
            {31'd0, !(m_scan && wr_if.wr_idx == m_y)});
    end

    task automatic wait_y(input string nm, input logic [1:0] tgt, input logic need_step, input int lim);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(Y == tgt && (!need_step || step)) && n < lim);
        chk(nm, {30'd0, Y}, {30'd0, tgt});
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        wr_if.wr_en   = 1'b0;
        wr_if.wr_idx  = 2'd0;
        wr_if.wr_data = 2'd0;
        repeat (2) @(negedge clk);
        chk("rst_X0", {30'd0, X0}, 32'd0);
        chk("rst_Y", {30'd0, Y}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_if.wr_ready}, 32'd1);
        rst = 1'b0;

        // Manual mode: fill channels then select channel 2.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr_if.wr_en   = 1'b1;
            wr_if.wr_idx  = 2'(i);
            wr_if.wr_data = 2'(wdat[i]);
        end
        @(negedge clk);
        wr_if.wr_en = 1'b0;
        man_sel     = 2'd2;
        @(posedge clk); #1;
        chk("man_Y", {30'd0, Y}, 32'd2);
        chk("man_X0", {30'd0, X0}, 32'd1);
        chk("man_X1", {30'd0, X1}, 32'd2);
        chk("man_X2", {30'd0, X2}, 32'd3);
        chk("man_X3", {30'd0, X3}, 32'd0);

        @(negedge clk);
        start   = 1'b1;
        man_sel = 2'd1;
        @(posedge clk); #1;
        chk("start_mode0_busy", {31'd0, busy}, 32'd0);
        chk("start_mode0_Y", {30'd0, Y}, 32'd1);
        @(negedge clk);
        start   = 1'b0;
        mode    = 1'b1;
        man_sel = 2'd3;
        @(posedge clk); #1;
        chk("mode1_hold_Y", {30'd0, Y}, 32'd1);

        // Auto-scan with dwell=2.
        @(negedge clk);
        dwell = 8'd2;
        start = 1'b1;
        for (int k = 0; k < 13; k++) begin
            @(posedge clk); #1;
            chk("scan_Y", {30'd0, Y}, 32'(scan_y[k]));
            chk("scan_step", {31'd0, step}, 32'(scan_s[k]));
            chk("scan_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
            start = 1'b0;
        end

        // Write to displayed channel 1 stalls until Y moves on.
        wait_y("wait_Y1", 2'd1, 1'b0, 10);
        @(negedge clk);
        wr_if.wr_en   = 1'b1;
        wr_if.wr_idx  = 2'd1;
        wr_if.wr_data = 2'd3;
        @(posedge clk); #1;
        chk("stall_ready", {31'd0, wr_if.wr_ready}, 32'd0);
        n = 0;
        while (!wr_if.wr_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stall_release_Y", {30'd0, Y}, 32'd2);
        chk("stall_X1_old", {30'd0, X1}, 32'd2);
        @(posedge clk); #1;
        chk("stall_X1_new", {30'd0, X1}, 32'd3);
        @(negedge clk);
        wr_if.wr_idx  = 2'd3;
        wr_if.wr_data = 2'd2;
        #1;
        chk("other_ready", {31'd0, wr_if.wr_ready}, 32'd1);
        @(posedge clk); #1;
        chk("other_X3", {30'd0, X3}, 32'd2);
        @(negedge clk);
        wr_if.wr_en = 1'b0;

        // Stop while Y=2.
        wait_y("wait_Y2", 2'd2, 1'b1, 20);
        @(negedge clk);
        stop = 1'b1;
        @(posedge clk); #1;
        chk("stop_busy", {31'd0, busy}, 32'd0);
        chk("stop_Y", {30'd0, Y}, 32'd2);
        chk("stop_step", {31'd0, step}, 32'd0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        chk("startstop_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        @(posedge clk); #1;
        chk("idle_hold_Y", {30'd0, Y}, 32'd2);

        // dwell=0 scan with start held high: no restart.
        @(negedge clk);
        dwell = 8'd0;
        start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("fast_Y", {30'd0, Y}, 32'(fast_y[k]));
            chk("fast_step", {31'd0, step}, 32'(fast_s[k]));
        end
        @(negedge clk);
        start   = 1'b0;
        mode    = 1'b0;
        man_sel = 2'd3;
        @(posedge clk); #1;
        chk("mode0_exit_busy", {31'd0, busy}, 32'd0);
        chk("mode0_exit_Y", {30'd0, Y}, 32'd1);
        chk("mode0_exit_step", {31'd0, step}, 32'd0);
        @(posedge clk); #1;
        chk("mode0_man_Y", {30'd0, Y}, 32'd3);

`ifdef MUX_SEL_SEQ_PAUSE_EN
        @(negedge clk);
        mode  = 1'b1;
        start = 1'b1;
        wait_y("wait_pause_Y1", 2'd1, 1'b0, 10);
        @(negedge clk);
        start = 1'b0;
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("pause_Y", {30'd0, Y}, 32'd1);
            chk("pause_step", {31'd0, step}, 32'd0);
            chk("pause_busy", {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        pause = 1'b0;
        @(posedge clk); #1;
        chk("unpause_Y", {30'd0, Y}, 32'd2);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
`endif

        // Reset mid-cycle during scan with a stalled write pending.
        @(negedge clk);
        mode  = 1'b1;
        dwell = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_y("wait_rst_Y1", 2'd1, 1'b0, 12);
        @(negedge clk);
        wr_if.wr_en   = 1'b1;
        wr_if.wr_idx  = 2'd1;
        wr_if.wr_data = 2'd1;
        @(posedge clk); #1;
        chk("rst_stall_ready", {31'd0, wr_if.wr_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_X0", {30'd0, X0}, 32'd0);
        chk("midrst_X1", {30'd0, X1}, 32'd0);
        chk("midrst_X2", {30'd0, X2}, 32'd0);
        chk("midrst_X3", {30'd0, X3}, 32'd0);
        chk("midrst_Y", {30'd0, Y}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_step", {31'd0, step}, 32'd0);
        chk("midrst_wr_ready", {31'd0, wr_if.wr_ready}, 32'd1);
        @(negedge clk);
        wr_if.wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_X1", {30'd0, X1}, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
- Upstream stage for the 4:1, 2-bit-per-channel select mux.
- Holds the four 2-bit channel values X0..X3 in registers written through a valid/ready port.
- Generates the 2-bit select Y in one of two modes:
  - manual: Y follows a registered copy of the man_sel input.
  - auto-scan: Y steps 0,1,2,3,0,... every dwell+1 cycles.
- Outputs connect 1:1 to the mux inputs X0..X3 and Y.

Parameters:
DWELL_W, 8, width of dwell counter and dwell input
DATA_W, 2, width of each channel value (must match mux data width)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
wr_en  input  1  channel write request
wr_idx  input  2  channel index 0..3 for write
wr_data  input  DATA_W  value to write
wr_ready  output  1  write accepted this cycle when wr_en&wr_ready
mode  input  1  0 = manual select, 1 = auto-scan permitted
man_sel  input  2  manual select value
dwell  input  DWELL_W  extra cycles Y is held per channel in scan
start  input  1  begin auto-scan (level sampled each cycle)
stop  input  1  end auto-scan
X0, X1, X2, X3  output  DATA_W  registered channel values to mux
Y  output  2  registered select to mux
busy  output  1  1 while in SCAN state
step  output  1  one-cycle pulse on every scan advance of Y

Behaviour:
- Reset (async, immediate): X0..X3=0, Y=0, state=IDLE, counter=0, busy=0, step=0. wr_ready is combinational and therefore 1 during reset.
- State machine has two states, IDLE and SCAN.
- IDLE:
  - If mode=0: Y <= man_sel each cycle (1-cycle latency).
  - If mode=1: Y holds its value.
  - start=1 & mode=1 & stop=0 -> SCAN next cycle, Y<=0, counter<=0, dwell captured.
  - start with mode=0 is ignored.
- SCAN:
  - counter increments each cycle.
  - When counter==dwell_q: Y<=Y+1 (mod 4, 3 wraps to 0), counter<=0, step=1 that cycle edge (registered pulse, high for the cycle after advance), dwell_q re-captured from dwell.
  - dwell=0 -> Y advances every cycle; period = dwell+1 cycles.
  - stop=1, or mode=0 -> IDLE next cycle; Y holds its last scan value; counter cleared; no step.
- Simultaneous start&stop: stop wins (IDLE stays IDLE, SCAN exits).
- start while already in SCAN: ignored (no restart).
- busy = (state==SCAN), registered with state.
- Writes:
  - wr_ready = !(state==SCAN && wr_idx==Y) (combinational). The channel currently displayed is frozen during its dwell.
  - On wr_en&wr_ready: X[wr_idx] <= wr_data; visible on X outputs the next cycle.
  - A stalled write completes in the first cycle Y moves away or scan ends. Requester must hold wr_en/wr_idx/wr_data stable until accepted.
  - In IDLE all writes are accepted, including to the channel equal to Y.
- Reset mid-scan: immediate return to the reset values above; pending stalled write is dropped.
- No arithmetic beyond the mod-4 Y increment and the DWELL_W-bit counter. The counter never exceeds dwell_q, so no overflow.

Optional Feature:
- Macro: MUX_SEL_SEQ_PAUSE_EN.
- Defined:
  - Adds input port pause (1 bit).
  - In SCAN with pause=1: counter and Y freeze, no step, busy stays 1.
  - stop still exits while paused.
  - Writes to the frozen channel remain stalled.
- Undefined: no pause port; scan runs free as above.

Test Plan:
- Reset with rst asserted mid-cycle -> X0..X3=0, Y=0, busy=0 immediately, before the next clk edge.
- IDLE, mode=0, write idx0..3 = 1,2,3,0 then man_sel=2 -> X2=3 next cycle; Y=2 one cycle after man_sel change.
- mode=1, dwell=2, start pulse -> busy=1; Y sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; step pulses every 3 cycles; wrap from 3 to 0 observed.
- SCAN with Y=1, write wr_idx=1 data=3 -> wr_ready=0 until Y becomes 2, then X1=3 one cycle later. A concurrent write to idx 3 is accepted immediately.
- start and stop both high in IDLE -> stays IDLE. In SCAN with Y=2, assert stop -> IDLE next cycle, Y stays 2, busy=0, no step.
- With MUX_SEL_SEQ_PAUSE_EN, dwell=0, pause high 5 cycles at Y=1 -> Y stays 1, no step; after release Y=2 next cycle.
